hazard_scoreboard: RTL

- Pipeline sequencing controller for the 5-stage datapath (IF/ID/EXEC/MEM/WB).
- Tracks in-flight register writes in a per-register countdown scoreboard and decides each cycle whether the instruction in ID may issue into EXEC.
- Drives the PC/IF-ID stall, ID-EX bubble and IF-ID flush controls, and handles branch/jump redirects and memory wait freezes.
- No forwarding network: a consumer waits until its producer has written back.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline sequencing controller for a 5-stage IF/ID/EXEC/MEM/WB datapath
//   without forwarding. A per-register countdown scoreboard records how many
//   cycles remain until each in-flight write is readable from the register
//   file. Each cycle the block decides whether the ID instruction may issue.
//
// Parameters
//   WB_LAT : cycles from producer issue until its result is readable (1..7)
//   CNT_W  : scoreboard counter width, 2**CNT_W > WB_LAT
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   id_valid          : ID holds a valid instruction
//   id_rs, id_rt      : ID source registers
//   id_uses_rs/rt     : ID instruction reads rs / rt
//   id_regwrite       : ID instruction writes a register
//   id_write_reg      : ID destination register (after RegDest select)
//   ex_redirect       : EXEC branch/jump redirects the PC this cycle
//   mem_wait          : data memory not ready, whole pipeline freezes
//   issue             : ID instruction advances into EXEC at this edge
//   stall_pc          : hold PC and IF/ID
//   bubble_id_ex      : load a NOP into ID/EX
//   flush_if_id       : replace IF/ID with a NOP
//   freeze            : hold every pipeline register (mirrors mem_wait)
//   stall_count       : saturating count of cycles lost to data hazards
module hazard_scoreboard #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_regwrite,
  input  logic [4:0]  id_write_reg,
  input  logic        ex_redirect,
  input  logic        mem_wait,
  output logic        issue,
  output logic        stall_pc,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        freeze,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WB_LAT);

  // Register 0 has no counter: it is hardwired and never busy.
  logic [CNT_W-1:0] cnt_r [1:31];
  logic [31:0]      stall_count_r;

  logic [31:0] busy_vec_s;
  logic        hazard_s;
  logic        issue_s;
  logic        stall_pc_s;
  logic        bubble_s;
  logic        flush_s;
  logic        freeze_s;
  logic        count_hazard_s;

  // Busy flags per register; bit 0 is tied low so r0 never causes a stall.
  always_comb begin
    busy_vec_s      = 32'd0;
    busy_vec_s[0]   = 1'b0;
    for (int r = 1; r < 32; r++) begin
      busy_vec_s[r] = (cnt_r[r] != '0);
    end
  end

  // Hazard uses the current (pre-update) counters, so a read-modify-write of
  // the same register sees the older producer before reloading the counter.
  always_comb begin
    hazard_s = id_valid & ((id_uses_rs & busy_vec_s[id_rs]) |
                           (id_uses_rt & busy_vec_s[id_rt]));
  end

  // Control decode: memory wait beats redirect, redirect beats data hazard.
  always_comb begin
    issue_s        = 1'b0;
    stall_pc_s     = 1'b0;
    bubble_s       = 1'b0;
    flush_s        = 1'b0;
    freeze_s       = 1'b0;
    count_hazard_s = 1'b0;
    if (mem_wait) begin
      // Redirect is ignored here; EXEC re-presents it once the wait clears.
      freeze_s   = 1'b1;
      stall_pc_s = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is killed, so it never reaches the scoreboard.
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (hazard_s) begin
      stall_pc_s     = 1'b1;
      bubble_s       = 1'b1;
      count_hazard_s = 1'b1;
    end else begin
      issue_s = id_valid;
    end
  end

  assign issue        = issue_s;
  assign stall_pc     = stall_pc_s;
  assign bubble_id_ex = bubble_s;
  assign flush_if_id  = flush_s;
  assign freeze       = freeze_s;
  assign stall_count  = stall_count_r;

  // Scoreboard countdown: an issuing write reloads its counter (winning over
  // the decrement); every other non-zero counter counts toward writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) begin
        cnt_r[r] <= '0;
      end
    end else if (!mem_wait) begin
      for (int r = 1; r < 32; r++) begin
        if (issue_s && id_regwrite && (id_write_reg == 5'(r))) begin
          cnt_r[r] <= LOAD_VAL;
        end else if (cnt_r[r] != '0) begin
          cnt_r[r] <= cnt_r[r] - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[r] <= '0;
        end
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        cnt_r[r] <= cnt_r[r];
      end
    end
  end

  // Hazard-stall cycle counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 32'd0;
    end else if (count_hazard_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

endmodule
